// File: rtl/kamacore_hazard_controller_if.sv
// Hazard-controller handshake bundle: pipeline hazard information in,
// per-register hold/flush/valid controls and stall statistics out.
interface kamacore_hazard_controller_if #(
  parameter int NUM_STAGES     = 5,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MC_LEN_WIDTH   = 6,
  parameter int CNT_WIDTH      = 32
);
  localparam int N = NUM_STAGES - 1;

  logic [REG_ADDR_WIDTH-1:0] id_rs1_a;
  logic [REG_ADDR_WIDTH-1:0] id_rs2_a;
  logic                      id_rs1_used;
  logic                      id_rs2_used;
  logic [REG_ADDR_WIDTH-1:0] ex_rd_a;
  logic                      ex_rd_we;
  logic                      ex_is_load;
  logic                      ex_mc_start;
  logic [MC_LEN_WIDTH-1:0]   ex_mc_len;
  logic                      branch_valid;
  logic                      mem_busy;
  logic                      pc_hold;
  logic [N-1:0]              stage_hold;
  logic [N-1:0]              stage_flush;
  logic [N-1:0]              stage_valid;
  logic                      branch_accept;
  logic [CNT_WIDTH-1:0]      stall_count;

  modport master (
    output id_rs1_a, id_rs2_a, id_rs1_used, id_rs2_used,
    output ex_rd_a, ex_rd_we, ex_is_load, ex_mc_start, ex_mc_len,
    output branch_valid, mem_busy,
    input  pc_hold, stage_hold, stage_flush, stage_valid, branch_accept, stall_count
  );

  modport slave (
    input  id_rs1_a, id_rs2_a, id_rs1_used, id_rs2_used,
    input  ex_rd_a, ex_rd_we, ex_is_load, ex_mc_start, ex_mc_len,
    input  branch_valid, mem_busy,
    output pc_hold, stage_hold, stage_flush, stage_valid, branch_accept, stall_count
  );
endinterface

// File: rtl/kamacore_hazard_controller.sv
// Central stall/flush controller: load-use, multi-cycle EX, memory wait and
// ID-branch handling, with per-register valid tracking and a stall counter.
module kamacore_hazard_controller #(
  parameter int NUM_STAGES     = 5,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MC_LEN_WIDTH   = 6,
  parameter int CNT_WIDTH      = 32
) (
  input logic clk,
  input logic rst,
  kamacore_hazard_controller_if.slave hz
);
  localparam int N = NUM_STAGES - 1;

  typedef enum logic {RUN, EX_WAIT} state_t;

  state_t                  state_reg, state_next;
  logic [MC_LEN_WIDTH-1:0] mc_cnt_reg, mc_cnt_next;
  logic [N-1:0]            valid_reg, valid_next;
  logic [CNT_WIDTH-1:0]    stall_cnt_reg;

  logic [N-1:0] hold_raw;
  logic [N-1:0] flush;
  logic [N-1:0] hold;
  logic         pc_hold;
  logic         accept;
  logic         mc_go;
  logic         mc_stall;
  logic         rs1_hit;
  logic         rs2_hit;
  logic         load_use;

  assign mc_go    = (state_reg == RUN) & hz.ex_mc_start & valid_reg[1]
                  & (hz.ex_mc_len >= MC_LEN_WIDTH'(2));
  // The final EX_WAIT cycle (counter at zero) is the release cycle and does not stall.
  assign mc_stall = mc_go | ((state_reg == EX_WAIT) & (mc_cnt_reg != '0));

  assign rs1_hit  = hz.id_rs1_used & (hz.id_rs1_a == hz.ex_rd_a);
  assign rs2_hit  = hz.id_rs2_used & (hz.id_rs2_a == hz.ex_rd_a);
  assign load_use = (state_reg == RUN) & valid_reg[0] & valid_reg[1]
                  & hz.ex_is_load & hz.ex_rd_we & (hz.ex_rd_a != '0)
                  & (rs1_hit | rs2_hit);

  always_comb begin
    hold_raw    = '0;
    flush       = '0;
    pc_hold     = 1'b0;
    accept      = 1'b0;
    state_next  = state_reg;
    mc_cnt_next = mc_cnt_reg;

    if (hz.mem_busy) begin
      // Everything upstream of MEM/WB waits; MEM/WB receives a bubble. FSM frozen.
      pc_hold       = 1'b1;
      hold_raw      = {1'b0, {(N-1){1'b1}}};
      flush[N-1]    = 1'b1;
    end else begin
      if (mc_stall) begin
        pc_hold     = 1'b1;
        hold_raw[0] = 1'b1;
        hold_raw[1] = 1'b1;
        flush[2]    = 1'b1;
      end else if (load_use) begin
        pc_hold     = 1'b1;
        hold_raw[0] = 1'b1;
        flush[1]    = 1'b1;
      end else if (hz.branch_valid & valid_reg[0]) begin
        accept      = 1'b1;
        flush[0]    = 1'b1;
      end

      unique case (state_reg)
        RUN: begin
          if (mc_go) begin
            state_next  = EX_WAIT;
            mc_cnt_next = hz.ex_mc_len - MC_LEN_WIDTH'(2);
          end
        end
        EX_WAIT: begin
          if (mc_cnt_reg == '0) begin
            state_next = RUN;
          end else begin
            mc_cnt_next = mc_cnt_reg - MC_LEN_WIDTH'(1);
          end
        end
        default: state_next = RUN;
      endcase
    end
  end

  assign hold = hold_raw & ~flush;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_valid
      if (gi == 0) begin : g_first
        always_comb begin
          if (flush[gi])     valid_next[gi] = 1'b0;
          else if (hold[gi]) valid_next[gi] = valid_reg[gi];
          else               valid_next[gi] = 1'b1;
        end
      end else begin : g_rest
        always_comb begin
          if (flush[gi])     valid_next[gi] = 1'b0;
          else if (hold[gi]) valid_next[gi] = valid_reg[gi];
          else               valid_next[gi] = valid_reg[gi-1];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= RUN;
      mc_cnt_reg    <= '0;
      valid_reg     <= '0;
      stall_cnt_reg <= '0;
    end else begin
      state_reg  <= state_next;
      mc_cnt_reg <= mc_cnt_next;
      valid_reg  <= valid_next;
      if (pc_hold && (stall_cnt_reg != {CNT_WIDTH{1'b1}})) begin
        stall_cnt_reg <= stall_cnt_reg + CNT_WIDTH'(1);
      end
    end
  end

  assign hz.pc_hold       = pc_hold;
  assign hz.stage_hold    = hold;
  assign hz.stage_flush   = flush;
  assign hz.stage_valid   = valid_reg;
  assign hz.branch_accept = accept;
  assign hz.stall_count   = stall_cnt_reg;
endmodule
